// File: rtl/ids_pkg.sv
// Shared types and defaults for the intrusion-detection histogram scan controller.
package ids_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_WAIT_CHI,
        S_CLEAR,
        S_DONE
    } state_t;

    localparam int          DEF_NUM_BINS   = 256;
    localparam logic [31:0] DEF_THRESHOLD  = 32'h0000_06A9;
    localparam int          DEF_ALARM_HITS = 2;
    localparam int          DEF_TIMEOUT    = 64;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ids_alarm_filter.sv
// Turns per-window chi-squared verdicts into a debounced alarm and a verdict count.
module ids_alarm_filter
    import ids_pkg::*;
#(
    parameter logic [31:0] THRESHOLD  = DEF_THRESHOLD,
    parameter int          ALARM_HITS = DEF_ALARM_HITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        accept,
    input  logic [31:0] chi_in,
    output logic        is_attacked,
    output logic [15:0] window_cnt
);

    localparam int             HW       = cnt_width(ALARM_HITS);
    localparam logic [HW-1:0]  HITS_MAX = HW'(ALARM_HITS);

    logic [HW-1:0] hit_cnt_reg, hit_cnt_next;
    logic          attacked_reg, attacked_next;
    logic [15:0]   window_cnt_reg, window_cnt_next;

    always_comb begin
        hit_cnt_next    = hit_cnt_reg;
        attacked_next   = attacked_reg;
        window_cnt_next = window_cnt_reg;
        if (accept) begin
            window_cnt_next = window_cnt_reg + 16'd1;
            if (chi_in <= THRESHOLD) begin
                hit_cnt_next  = (hit_cnt_reg == HITS_MAX) ? HITS_MAX : hit_cnt_reg + HW'(1);
                attacked_next = (hit_cnt_next == HITS_MAX);
            end else begin
                // Any clean window breaks the run of suspicious ones.
                hit_cnt_next  = '0;
                attacked_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt_reg    <= '0;
            attacked_reg   <= 1'b0;
            window_cnt_reg <= '0;
        end else begin
            hit_cnt_reg    <= hit_cnt_next;
            attacked_reg   <= attacked_next;
            window_cnt_reg <= window_cnt_next;
        end
    end

    assign is_attacked = attacked_reg;
    assign window_cnt  = window_cnt_reg;

endmodule

// File: rtl/ids_scan_ctrl.sv
// Window controller: sweeps the E/O histograms to the chi-squared engine, waits for the
// verdict, clears the O histogram and hands the verdict to the alarm filter.
module ids_scan_ctrl
    import ids_pkg::*;
#(
    parameter int          NUM_BINS   = DEF_NUM_BINS,
    parameter logic [31:0] THRESHOLD  = DEF_THRESHOLD,
    parameter int          ALARM_HITS = DEF_ALARM_HITS,
    parameter int          TIMEOUT    = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [7:0]  addr,
    output logic        rd_en,
    input  logic [15:0] e_rd,
    input  logic [15:0] o_rd,
    output logic [15:0] e_out,
    output logic [15:0] o_out,
    output logic        pair_vld,
    output logic        pair_last,
    input  logic [31:0] chi_in,
    input  logic        chi_vld,
    output logic        o_we,
    output logic        is_attacked,
    output logic        timeout_err,
    output logic [15:0] window_cnt
);

    localparam logic [7:0]    LAST_ADDR = 8'(NUM_BINS - 1);
    localparam int            WW        = cnt_width(TIMEOUT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    state_t        state_reg, state_next;
    logic [7:0]    addr_reg, addr_next;
    logic [WW-1:0] wait_reg, wait_next;
    logic          timeout_err_reg, timeout_err_next;
    logic          pair_vld_reg;
    logic          accept;

    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        wait_next        = wait_reg;
        timeout_err_next = timeout_err_reg;
        accept           = 1'b0;
        busy             = 1'b1;
        done             = 1'b0;
        rd_en            = 1'b0;
        o_we             = 1'b0;
        case (state_reg)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next       = S_SWEEP;
                    addr_next        = '0;
                    timeout_err_next = 1'b0;
                end
            end
            S_SWEEP: begin
                rd_en = 1'b1;
                if (addr_reg == LAST_ADDR) begin
                    state_next = S_DRAIN;
                    addr_next  = '0;
                end else begin
                    addr_next = addr_reg + 8'd1;
                end
            end
            S_DRAIN: begin
                state_next = S_WAIT_CHI;
                wait_next  = '0;
            end
            S_WAIT_CHI: begin
                // A verdict on the final allowed cycle beats the timeout.
                if (chi_vld) begin
                    accept     = 1'b1;
                    state_next = S_CLEAR;
                end else if (wait_reg == WAIT_LAST) begin
                    timeout_err_next = 1'b1;
                    state_next       = S_CLEAR;
                end else begin
                    wait_next = wait_reg + WW'(1);
                end
            end
            S_CLEAR: begin
                o_we = 1'b1;
                if (addr_reg == LAST_ADDR) begin
                    state_next = S_DONE;
                    addr_next  = '0;
                end else begin
                    addr_next = addr_reg + 8'd1;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= S_IDLE;
            addr_reg        <= '0;
            wait_reg        <= '0;
            timeout_err_reg <= 1'b0;
            pair_vld_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            wait_reg        <= wait_next;
            timeout_err_reg <= timeout_err_next;
            pair_vld_reg    <= (state_reg == S_SWEEP);
        end
    end

    // The RAM output register is the pipeline stage for the bin pair; it is only
    // forwarded while a pair is valid so the engine never sees stale data.
    assign e_out       = pair_vld_reg ? e_rd : 16'h0000;
    assign o_out       = pair_vld_reg ? o_rd : 16'h0000;
    assign pair_vld    = pair_vld_reg;
    assign pair_last   = (state_reg == S_DRAIN);
    assign addr        = addr_reg;
    assign timeout_err = timeout_err_reg;

    ids_alarm_filter #(
        .THRESHOLD  (THRESHOLD),
        .ALARM_HITS (ALARM_HITS)
    ) u_alarm (
        .clk         (clk),
        .rst         (rst),
        .accept      (accept),
        .chi_in      (chi_in),
        .is_attacked (is_attacked),
        .window_cnt  (window_cnt)
    );

endmodule

// File: tb/tb_ids_scan_ctrl.sv
// Self-checking bench for ids_scan_ctrl with a 4-bin histogram RAM model.
module tb_ids_scan_ctrl;

    localparam int N  = 4;
    localparam int AH = 2;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst, start, chi_vld;
    logic [31:0] chi_in;
    logic [15:0] e_rd, o_rd;
    logic        busy, done, rd_en, pair_vld, pair_last, o_we, is_attacked, timeout_err;
    logic [7:0]  addr;
    logic [15:0] e_out, o_out, window_cnt;

    ids_scan_ctrl #(
        .NUM_BINS   (N),
        .THRESHOLD  (32'h0000_06A9),
        .ALARM_HITS (AH),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .addr        (addr),
        .rd_en       (rd_en),
        .e_rd        (e_rd),
        .o_rd        (o_rd),
        .e_out       (e_out),
        .o_out       (o_out),
        .pair_vld    (pair_vld),
        .pair_last   (pair_last),
        .chi_in      (chi_in),
        .chi_vld     (chi_vld),
        .o_we        (o_we),
        .is_attacked (is_attacked),
        .timeout_err (timeout_err),
        .window_cnt  (window_cnt)
    );

    always #5 clk = ~clk;

    // Histogram RAMs: registered read, O side cleared by o_we, bulk-loaded by fill.
    logic [15:0] e_mem [N];
    logic [15:0] o_mem [N];
    logic [15:0] fill_e [N];
    logic [15:0] fill_o [N];
    logic        fill = 1'b0;

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < N; i++) begin
                e_mem[i] <= fill_e[i];
                o_mem[i] <= fill_o[i];
            end
        end else begin
            if (rd_en) begin
                e_rd <= e_mem[addr[1:0]];
                o_rd <= o_mem[addr[1:0]];
            end
            if (o_we) o_mem[addr[1:0]] <= 16'h0000;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard of bin pairs expected on the engine interface.
    typedef struct packed {
        logic [15:0] e;
        logic [15:0] o;
        logic        last;
    } pair_t;
    pair_t sb_q[$];

    always @(negedge clk) begin
        if (rst === 1'b1 && pair_vld === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pair_unexpected @cyc %0d: got pair %h/%h expected none", cyc, e_out, o_out);
            end else begin
                pair_t p;
                p = sb_q.pop_front();
                chk("pair", {31'b0, e_out, o_out, pair_last}, {31'b0, p.e, p.o, p.last});
            end
        end
    end

    typedef struct {
        int          delay;   // WAIT_CHI cycle of the chi_vld pulse, -1 for none
        logic [31:0] chi;
        bit          noise;   // stray start in SWEEP, stray chi_vld in SWEEP/CLEAR
        logic        att;
        logic [15:0] wcnt;
        logic        err;
    } vec_t;

    vec_t tbl[10];
    logic m_err = 1'b0;

    task automatic refill();
        for (int i = 0; i < N; i++) begin
            fill_e[i] = 16'($urandom);
            fill_o[i] = 16'($urandom);
        end
        fill = 1'b1;
        @(negedge clk);
        fill = 1'b0;
        @(negedge clk);
    endtask

    // Entered at a negedge; that negedge is cycle 0 of the window.
    task automatic run_window(input int delay, input logic [31:0] chi, input bit noise);
        bit         acc;
        int         k_c, k_done;
        logic [6:0] exp_v;
        logic [7:0] exp_addr;
        logic       o_clean;
        acc    = (delay >= 0) && (delay < TO);
        k_c    = acc ? (N + 3 + delay) : (N + 2 + TO);
        k_done = k_c + N;
        for (int i = 0; i < N; i++) sb_q.push_back('{fill_e[i], fill_o[i], (i == N - 1)});
        for (int k = 0; k <= k_done + 2; k++) begin
            start   = (k == 0) || (noise && k == 2);
            chi_vld = (delay >= 0 && k == N + 2 + delay) || (noise && (k == 1 || k == k_c + 1));
            chi_in  = (delay >= 0 && k == N + 2 + delay) ? chi : 32'h0000_0000;
            exp_v = {k >= 1 && k <= k_done,
                     k >= 1 && k <= N,
                     k >= 2 && k <= N + 1,
                     k == N + 1,
                     k >= k_c && k < k_c + N,
                     k == k_done,
                     (k == 0) ? m_err : (!acc && k >= k_c)};
            chk("ctrl_busy_rd_pv_pl_we_done_err",
                {57'b0, busy, rd_en, pair_vld, pair_last, o_we, done, timeout_err}, {57'b0, exp_v});
            if (k >= 1 && k <= N)             exp_addr = 8'(k - 1);
            else if (k >= k_c && k < k_c + N) exp_addr = 8'(k - k_c);
            else                              exp_addr = 8'h00;
            chk("addr", {56'b0, addr}, {56'b0, exp_addr});
            @(negedge clk);
        end
        start   = 1'b0;
        chi_vld = 1'b0;
        chk("pairs_outstanding", 64'(sb_q.size()), 64'd0);
        o_clean = 1'b1;
        for (int i = 0; i < N; i++) if (o_mem[i] !== 16'h0000) o_clean = 1'b0;
        chk("o_ram_cleared", {63'b0, o_clean}, 64'd1);
    endtask

    task automatic check_verdict(input string tag, input logic att, input logic [15:0] wcnt, input logic err);
        chk({tag, "_is_attacked"}, {63'b0, is_attacked}, {63'b0, att});
        chk({tag, "_window_cnt"},  {48'b0, window_cnt},  {48'b0, wcnt});
        chk({tag, "_timeout_err"}, {63'b0, timeout_err}, {63'b0, err});
        $display("window %s: att=%0b wcnt=%h err=%0b", tag, is_attacked, window_cnt, timeout_err);
        m_err = err;
    endtask

    initial begin
        tbl[0] = '{0,  32'h0000_06A9, 1'b0, 1'b0, 16'd1, 1'b0};
        tbl[1] = '{3,  32'h0000_0100, 1'b0, 1'b1, 16'd2, 1'b0};
        tbl[2] = '{0,  32'h0000_06AA, 1'b0, 1'b0, 16'd3, 1'b0};
        tbl[3] = '{-1, 32'h0000_0000, 1'b0, 1'b0, 16'd3, 1'b1};
        tbl[4] = '{7,  32'h0000_0000, 1'b0, 1'b0, 16'd4, 1'b0};
        tbl[5] = '{2,  32'h0000_06A9, 1'b1, 1'b1, 16'd5, 1'b0};
        tbl[6] = '{-1, 32'h0000_0000, 1'b1, 1'b1, 16'd5, 1'b1};
        tbl[7] = '{8,  32'h0000_0000, 1'b0, 1'b1, 16'd5, 1'b1};
        tbl[8] = '{1,  32'h0000_0010, 1'b0, 1'b1, 16'd6, 1'b0};
        tbl[9] = '{0,  32'hFFFF_FFFF, 1'b0, 1'b0, 16'd7, 1'b0};

        rst = 1'b0; start = 1'b0; chi_vld = 1'b0; chi_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {busy, done, rd_en, o_we, pair_vld, pair_last, is_attacked, timeout_err, addr, e_out, o_out, window_cnt},
            64'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 10; r++) begin
            refill();
            run_window(tbl[r].delay, tbl[r].chi, tbl[r].noise);
            check_verdict($sformatf("row%0d", r), tbl[r].att, tbl[r].wcnt, tbl[r].err);
        end

        // Reset during SWEEP: everything drops, no done, no resumption.
        refill();
        for (int i = 0; i < N; i++) sb_q.push_back('{fill_e[i], fill_o[i], (i == N - 1)});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midsweep_reset_outputs",
            {busy, done, rd_en, o_we, pair_vld, pair_last, is_attacked, timeout_err, addr, e_out, o_out, window_cnt},
            64'd0);
        rst = 1'b1;
        sb_q.delete();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_reset_idle_busy_done", {62'b0, busy, done}, 64'd0);
        end
        m_err = 1'b0;
        refill();
        run_window(1, 32'h0000_0100, 1'b0);
        check_verdict("after_reset", 1'b0, 16'd1, 1'b0);

        // Jump the verdict counter near its top so the wrap is reached in a few windows.
        force dut.u_alarm.window_cnt_reg = 16'hFFFE;
        @(negedge clk);
        release dut.u_alarm.window_cnt_reg;
        @(negedge clk);
        refill();
        run_window(0, 32'h0000_2000, 1'b0);
        check_verdict("cnt_ffff", 1'b0, 16'hFFFF, 1'b0);
        refill();
        run_window(0, 32'h0000_2000, 1'b0);
        check_verdict("cnt_wrap", 1'b0, 16'h0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
